// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one operand bit per RUN cycle through a single full_adder.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             busy_r;
    logic             done_r;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_r;
`endif

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] sum_sh_s;
    logic             last_bit_s;
    logic             accept_s;

    full_adder u_fa (
        .a     (a_sr_r[0]),
        .b     (b_sr_r[0]),
        .c_in  (carry_r),
        .sum   (fa_sum_s),
        .c_out (fa_cout_s)
    );

    // Next sum shift-register value: new bit enters at the MSB.
    always_comb begin
        sum_sh_s            = sum_sr_r >> 1'b1;
        sum_sh_s[WIDTH-1]   = fa_sum_s;
    end

    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));
    assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));

    // FSM, datapath shift registers and registered results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_sr_r   <= {WIDTH{1'b0}};
            b_sr_r   <= {WIDTH{1'b0}};
            sum_sr_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            c_out_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                RUN: begin
                    a_sr_r   <= a_sr_r >> 1'b1;
                    b_sr_r   <= b_sr_r >> 1'b1;
                    sum_sr_r <= sum_sh_s;
                    carry_r  <= fa_cout_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        state_r <= DONE;
                        sum_r   <= sum_sh_s;
                        c_out_r <= fa_cout_s;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_r here is the carry into the MSB
                        ovf_r   <= carry_r ^ fa_cout_s;
`endif
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                IDLE, DONE: begin
                    if (accept_s) begin
                        a_sr_r   <= a;
                        b_sr_r   <= b;
                        sum_sr_r <= {WIDTH{1'b0}};
                        carry_r  <= c_in;
                        cnt_r    <= {CW{1'b0}};
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                    end
                    done_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign c_out = c_out_r;
`ifdef SERIAL_ADD_OVF_EN
    assign overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic
// reference model; overflow is checked when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = 8'h00;
    logic [W-1:0] b = 8'h00;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    always #20 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic ci);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + (ci ? 1 : 0);
        return (s > 127) || (s < -128);
    endfunction

    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        @(negedge clk);
        a = x; b = y; c_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    endtask

    // Returns negedges waited until done seen, and busy-high samples on the way.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0; busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
        checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", c_out); end
`ifdef SERIAL_ADD_OVF_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
`endif
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy %b expected 0", busy); end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic ci, input int lat, input int exp_lat);
        logic [W:0] e;
        e = ref_add(x, y, ci);
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        checks++; if (sum !== e[W-1:0]) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, sum, e[W-1:0]); end
        checks++; if (c_out !== e[W]) begin errors++; $display("FAIL %s_cout: got %b expected %b", name, c_out, e[W]); end
`ifdef SERIAL_ADD_OVF_EN
        checks++; if (overflow !== ref_ovf(x, y, ci)) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, overflow, ref_ovf(x, y, ci)); end
`endif
    endtask

    task automatic test_basic();
        int lat, bc;
        do_start(8'h35, 8'h4A, 1'b0);
        wait_done(lat, bc);
        check_result("basic", 8'h35, 8'h4A, 1'b0, lat, W);
        checks++; if (bc != W) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
        checks++; if (sum !== 8'h7F) begin errors++; $display("FAIL basic_sum_hold: got %h expected 7f", sum); end
    endtask

    task automatic test_carry_wrap();
        int lat, bc;
        do_start(8'hFF, 8'h01, 1'b0);
        wait_done(lat, bc);
        check_result("wrap_ff", 8'hFF, 8'h01, 1'b0, lat, W);
        do_start(8'h7F, 8'h01, 1'b0);
        wait_done(lat, bc);
        check_result("wrap_7f", 8'h7F, 8'h01, 1'b0, lat, W);
    endtask

    task automatic test_ignored_start();
        int lat, bc, extra;
        do_start(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b expected 1", busy); end
        wait_done(lat, bc);
        check_result("ignored", 8'h10, 8'h20, 1'b0, lat + 3, W);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ign_extra_activity: got %0d cycles expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [W-1:0] x2, y2;
        logic ci2;
        @(negedge clk);
        a = 8'h01; b = 8'h02; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        wait_done(lat, bc);
        check_result("b2b_first", 8'h01, 8'h02, 1'b1, lat, W);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: busy %b expected 1", busy); end
        wait_done(lat, bc);
        check_result("b2b_second", 8'h01, 8'h02, 1'b1, lat + 1, W + 1);
        // Restart from DONE with fresh operands; sum must hold the old result.
        for (int i = 0; i < 4; i++) begin
            x2 = 8'($urandom); y2 = 8'($urandom); ci2 = 1'($urandom);
            a = x2; b = y2; c_in = ci2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            checks++; if (sum !== 8'h04 && i == 0) begin errors++; $display("FAIL b2b_hold: got %h expected 04", sum); end
            wait_done(lat, bc);
            check_result("b2b_rand", x2, y2, ci2, lat + 4, W + 1);
            if (i == 3) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, seen;
        do_start(8'hC3, 8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_mid_sum: got %h expected 00", sum); end
        checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL rst_mid_cout: got %b expected 0", c_out); end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", seen); end
        do_start(8'h12, 8'h34, 1'b0);
        wait_done(lat, bc);
        check_result("rst_mid_after", 8'h12, 8'h34, 1'b0, lat, W);
    endtask

    task automatic test_random();
        int lat, bc;
        logic [W-1:0] x, y;
        logic ci;
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
            do_start(x, y, ci);
            wait_done(lat, bc);
            check_result("random", x, y, ci, lat, W);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_wrap();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
- REQ-001: The block SHALL have one clock; reset SHALL be synchronous and active-low.
- REQ-002: Parameter WIDTH SHALL default to 8 and set the operand width in bits; legal range is 1..64.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst_n  input  1  synchronous active-low reset.
- REQ-005: start  input  1  request to begin an addition; sampled high on a clk edge.
- REQ-006: a  input  WIDTH  first operand; sampled only on an accepted start.
- REQ-007: b  input  WIDTH  second operand; sampled only on an accepted start.
- REQ-008: c_in  input  1  carry-in; sampled only on an accepted start.
- REQ-009: busy  output  1  high while an addition is in progress (RUN state).
- REQ-010: done  output  1  single-cycle pulse; sum and c_out are valid and updated in this cycle.
- REQ-011: sum  output  WIDTH  registered result.
- REQ-012: c_out  output  1  registered carry-out of the MSB.

Function
- REQ-013: The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-014: start SHALL be accepted in IDLE or DONE. On acceptance, a, b and c_in SHALL load into operand shift registers and the carry register, the bit counter SHALL clear, and the FSM SHALL go to RUN.
- REQ-015: Each RUN cycle SHALL add the LSBs of the operand shift registers and the carry register through one full_adder instance, then:
  - shift both operand registers right by 1;
  - shift the sum bit into the MSB of the internal sum shift register;
  - load the full_adder c_out into the carry register;
  - increment the counter.
- REQ-016: After exactly WIDTH RUN cycles, the FSM SHALL go to DONE. In the same edge, sum SHALL load from the completed shift register and c_out SHALL load from the final carry.
- REQ-017: done SHALL be high for exactly one cycle, in DONE. If DONE is not followed by an accepted start, the FSM SHALL go to IDLE.
- REQ-018: Latency: a start accepted at edge t SHALL produce done high in the cycle after edge t+WIDTH.
- REQ-019: start during RUN SHALL be ignored, with no change to operands, counter or outputs.
- REQ-020: start in DONE SHALL begin a new operation; done still pulses that cycle and sum holds its value until the new operation completes.
- REQ-021: sum and c_out SHALL change only on the DONE-entry edge or on reset; intermediate bits SHALL never be visible.
- REQ-022: Arithmetic SHALL be unsigned modulo 2^WIDTH, with the carry beyond the MSB on c_out.
- REQ-023: The counter SHALL be $clog2(WIDTH+1) bits wide.

Reset
- REQ-024: When rst_n is low on a clk edge, the FSM SHALL go to IDLE and busy, done, sum, c_out, the carry register, the counter and the shift registers SHALL all clear to 0.
- REQ-025: Reset during RUN SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
- REQ-026: start asserted in the same cycle as rst_n low SHALL be ignored.

Configuration
- REQ-027: Macro SERIAL_ADD_OVF_EN defined: the block SHALL add output port "overflow  output  1".
  - overflow = carry into the MSB XOR final carry-out.
  - overflow SHALL be registered with sum, reset to 0, and held with sum.
- REQ-028: Macro SERIAL_ADD_OVF_EN undefined: the overflow port and its register SHALL be absent. All other behaviour SHALL be identical.

Structure
- REQ-029: Shared package serial_add_pkg SHALL hold:
  - the FSM state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant.
- REQ-030: The datapath bit SHALL use exactly one instance of the existing full_adder sub-module. No other adder logic is permitted.
- REQ-031: The clock period used by the bench SHALL exceed the full_adder propagation delay (20 ns minimum).

Verification (WIDTH=8)
- REQ-032: Reset: rst_n low for 3 cycles -> busy=0, done=0, sum=8'h00, c_out=0.
- REQ-033: Basic add: a=8'h35, b=8'h4A, c_in=0, start for 1 cycle -> busy high for 8 cycles, then done pulse with sum=8'h7F, c_out=0, overflow=0.
- REQ-034: Carry wrap: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, overflow=0. Also a=8'h7F, b=8'h01 -> sum=8'h80, c_out=0, overflow=1.
- REQ-035: Ignored start: start for 8'h10+8'h20; during RUN cycle 3, start with a=8'hAA, b=8'h55 -> result sum=8'h30 and exactly one done pulse.
- REQ-036: Back-to-back: start held through DONE with a=8'h01, b=8'h02, c_in=1 -> second done 9 cycles after the first, with sum=8'h04.
- REQ-037: Reset mid-op: rst_n low at RUN cycle 4 -> state IDLE, sum=0, no done. A following start with 8'h12+8'h34 -> sum=8'h46 with normal latency.
